// File: rtl/router_pkg.sv
// Shared constants and helpers for the router output-side synchroniser.
// Used by the top level and the per-port timeout counters.
package router_pkg;

  localparam int MAX_PORTS       = 16;
  localparam int DEFAULT_TIMEOUT = 30;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Out-of-range index decodes to all zeros.
  function automatic logic [MAX_PORTS-1:0] onehot_dec(
    input int index,
    input int width
  );
    logic [MAX_PORTS-1:0] r;
    r = '0;
    if (index >= 0 && index < width && index < MAX_PORTS)
      r = MAX_PORTS'(1) << index;
    return r;
  endfunction

endpackage

// File: rtl/router_timeout_ctr.sv
// Per-port unread-data watchdog: raises soft_reset after TIMEOUT
// consecutive unread valid cycles and keeps a sticky flag of it.
module router_timeout_ctr
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = clog2(DEFAULT_TIMEOUT + 1)
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  input  logic clr,
  output logic soft_reset,
  output logic timeout_flag
);

  logic [CNT_W-1:0] cnt;
  logic             fire;

  assign fire = vld && !rd && !soft_reset &&
                (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!vld || rd) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (soft_reset) begin
      cnt        <= '0;
    end else if (fire) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
    end
  end

  // A new timeout beats a simultaneous clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      timeout_flag <= 1'b0;
    else if (fire)
      timeout_flag <= 1'b1;
    else if (clr)
      timeout_flag <= 1'b0;
  end

endmodule

// File: rtl/router_sync_param.sv
// Synchroniser between the router FSM and NUM_PORTS output FIFOs:
// destination latch, write-enable/full muxing and per-port timeouts.
module router_sync_param
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic                 write_enb_reg,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] timeout_clr,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic [NUM_PORTS-1:0] timeout_flag,
  output logic                 addr_err
);

  localparam int CNT_W = clog2(TIMEOUT + 1);

  logic [ADDR_W-1:0]    dest;
  logic                 dest_valid;
  logic                 in_range;
  logic [NUM_PORTS-1:0] sel;

  assign in_range = 32'(data_in) < NUM_PORTS;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dest       <= '0;
      dest_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      addr_err <= detect_add && !in_range;
      if (detect_add) begin
        dest       <= data_in;
        dest_valid <= in_range;
      end
    end
  end

  // Decode uses the registered dest, so a same-cycle header
  // only takes effect on the following cycle.
  always_comb begin
    sel = NUM_PORTS'(onehot_dec(int'(dest), NUM_PORTS));
  end

  assign fifo_full = dest_valid && |(sel & full);
  assign write_enb = (write_enb_reg && dest_valid) ? sel : '0;
  assign vld_out   = ~empty;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    router_timeout_ctr #(
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
    ) u_ctr (
      .clock       (clock),
      .resetn      (resetn),
      .vld         (vld_out[i]),
      .rd          (read_enb[i]),
      .clr         (timeout_clr[i]),
      .soft_reset  (soft_reset[i]),
      .timeout_flag(timeout_flag[i])
    );
  end

endmodule

// File: doc/router_sync_param.md
Name: router_sync_param

Overview:
- Parametrised synchroniser between the router FSM and NUM_PORTS output FIFOs.
- Latches the destination address from the header, and generates one-hot write enables and the selected-FIFO full flag.
- Drives valid-out from FIFO empty flags, and generates per-port soft resets after TIMEOUT unread cycles.
- Adds over the previous generation: any port count, configurable timeout, invalid-address detection, sticky per-port timeout flags with clear.

Parameters:
- NUM_PORTS, 3, number of output FIFOs/ports (2..16).
- ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_PORTS.
- TIMEOUT, 30, consecutive unread valid cycles before soft reset (2..1023).
- CNT_W, localparam = clog2(TIMEOUT+1), timeout counter width.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- detect_add  in  1  FSM: header byte present, capture address.
- write_enb_reg  in  1  FSM: payload write strobe.
- data_in  in  ADDR_W  address field of header byte.
- read_enb  in  NUM_PORTS  per-port destination read enable.
- full  in  NUM_PORTS  per-FIFO full.
- empty  in  NUM_PORTS  per-FIFO empty.
- timeout_clr  in  NUM_PORTS  clears the matching timeout_flag bit.
- fifo_full  out  1  full flag of the currently selected FIFO.
- write_enb  out  NUM_PORTS  one-hot FIFO write enable.
- vld_out  out  NUM_PORTS  data available at port.
- soft_reset  out  NUM_PORTS  per-FIFO soft reset.
- timeout_flag  out  NUM_PORTS  sticky: soft reset has occurred on port.
- addr_err  out  1  one-cycle pulse: captured address >= NUM_PORTS.

Behaviour:
- Reset (resetn low, asynchronous): dest=0, dest_valid=0, all counters=0, soft_reset=0, timeout_flag=0, addr_err=0.
  - Combinational outputs follow: write_enb=0, fifo_full=0.
  - Release is synchronous to the next clock edge.
- Address capture, on a clock edge with detect_add=1:
  - dest <= data_in.
  - dest_valid <= (data_in < NUM_PORTS).
  - addr_err <= !(data_in < NUM_PORTS), high for exactly one cycle; otherwise addr_err <= 0.
  - dest/dest_valid hold until the next detect_add.
- fifo_full (combinational): full[dest] if dest_valid, else 0.
- write_enb (combinational): one-hot (1<<dest) if write_enb_reg && dest_valid, else 0.
  - Never more than one bit set.
  - With detect_add and write_enb_reg in the same cycle, write_enb decodes the previously registered dest; the new address takes effect the following cycle.
- vld_out[i] = ~empty[i], combinational, no latency.
- Per-port timeout, evaluated independently per port i at each clock edge, in priority order:
  - if empty[i] or read_enb[i]: cnt <= 0, soft_reset[i] <= 0.
  - else if soft_reset[i]: cnt <= 0, soft_reset[i] holds 1.
  - else if cnt == TIMEOUT-1: cnt <= 0, soft_reset[i] <= 1.
  - else: cnt <= cnt+1.
  - Net effect: soft_reset[i] rises after the TIMEOUT-th consecutive edge with vld_out[i]=1 and read_enb[i]=0.
  - It stays high until empty[i] or read_enb[i]. Once it clears with vld_out still high, counting restarts from 0.
  - The counter never wraps: its maximum value is TIMEOUT-1.
- timeout_flag[i]:
  - set on the edge where soft_reset[i] goes 0->1;
  - else cleared when timeout_clr[i]=1;
  - set wins over a simultaneous clear.
- Reset mid-operation: all state clears immediately, including any soft_reset in progress.
- Out-of-range dest: no write_enb, fifo_full=0, counters unaffected.

Decomposition:
- Package router_pkg:
  - constants MAX_PORTS=16 and DEFAULT_TIMEOUT=30;
  - function clog2;
  - function onehot_dec(index, width).
- Sub-module router_timeout_ctr, one per port via generate:
  - inputs clock, resetn, vld, rd, clr;
  - outputs soft_reset, timeout_flag;
  - parameters TIMEOUT, CNT_W.
- Top level holds the address register, write-enable/full muxing, addr_err, and the generate loop.

Test Plan:
- Defaults; detect_add with data_in=2'b01, then write_enb_reg=1 for 4 cycles -> write_enb=3'b010 in each of those cycles; fifo_full tracks full[1] only.
- data_in=2'b11 with detect_add -> addr_err high exactly 1 cycle; subsequent write_enb_reg gives write_enb=0 and fifo_full=0 even with full=3'b111.
- empty[0]=0, read_enb[0]=0 held -> soft_reset[0]=0 after 29 edges, 1 after edge 30, timeout_flag[0]=1; read_enb[0] pulse -> soft_reset[0]=0 next edge, timeout_flag[0] stays 1.
- read_enb[2] pulsed every 29th cycle with empty[2]=0 for 200 cycles -> soft_reset[2] never asserts.
- timeout_clr[1] asserted on the same edge soft_reset[1] rises -> timeout_flag[1]=1; clear one cycle later -> 0.
- NUM_PORTS=5, ADDR_W=3, TIMEOUT=4; soft_reset[3] mid-count when resetn is pulsed low asynchronously between edges -> all outputs 0 immediately; address 3'b100 selects write_enb=5'b10000.
